// File: rtl/mem_seq_pkg.sv
// Shared types for the memory command sequencer: bus widths, command record and FSM states.
package mem_seq_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 4;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitRd,
      StResp
   } state_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
// In-order command FIFO. DEPTH must be a power of two so the pointers wrap for free.
module mem_cmd_fifo
   import mem_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  cmd_t push_data_i,
   input  logic pop_i,
   output cmd_t pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

   cmd_t            mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o     = (count_q == FullCount);
   assign empty_o    = (count_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy is governed by count_q alone.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Queues read/write commands and issues them one at a time to a simple memory port.
// Define MEMSEQ_TIMEOUT_EN to add a read-response watchdog that returns an error response.
module mem_cmd_sequencer
   import mem_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              cmd_ready,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   input  logic              rsp_ready
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
   begin : g_param_check
      $error("mem_cmd_sequencer: bad FIFO_DEPTH or TIMEOUT_CYCLES");
   end

   cmd_t   cmd_in;
   cmd_t   fifo_head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_pop;

   state_e            state_q;
   logic              write_q;
   logic              mem_wr_q;
   logic              mem_rd_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [ADDR_W-1:0] rsp_addr_q;

`ifdef MEMSEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] wait_cnt_q;
   logic            rsp_err_q;
`endif

   assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
   assign cmd_ready = !fifo_full;
   assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

   mem_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (cmd_valid),
      .push_data_i (cmd_in),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Strobes are registered out of ISSUE, so they appear the cycle after the FSM leaves it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_addr_q  <= '0;
`ifdef MEMSEQ_TIMEOUT_EN
         wait_cnt_q  <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         mem_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (fifo_pop) begin
                  write_q     <= fifo_head.write;
                  mem_addr_q  <= fifo_head.addr;
                  mem_wdata_q <= fifo_head.wdata;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               mem_wr_q <= write_q;
               mem_rd_q <= !write_q;
               state_q  <= write_q ? StIdle : StWaitRd;
`ifdef MEMSEQ_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            StWaitRd: begin
               if (mem_valid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= mem_rdata;
                  rsp_addr_q  <= mem_addr_q;
                  state_q     <= StResp;
`ifdef MEMSEQ_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
               end else if (wait_cnt_q == CntLast) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_addr_q  <= mem_addr_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  wait_cnt_q  <= wait_cnt_q + 1'b1;
`endif
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_wr    = mem_wr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;
`ifdef MEMSEQ_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule
